mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit that sits directly downstream of the ALU source-B operand multiplexer.
- Consumes the A-register operand and the selected B operand and produces HI/LO results for MULT and DIV instructions.
- Runs iteratively (one step per clock) under a start/done handshake with the control FSM, which stalls while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_mult  input  1  request signed multiply; sampled only in IDLE.
- start_div  input  1  request signed divide; sampled only in IDLE.
- w_opA  input  WIDTH  multiplicand / dividend (A register).
- w_opB  input  WIDTH  multiplier / divisor (ALU source-B mux output).
- w_hi  output  WIDTH  HI register: product[2W-1:W] or remainder.
- w_lo  output  WIDTH  LO register: product[W-1:0] or quotient.
- busy  output  1  high in MULT, DIV and DONE states.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  sticky flag: last DIV had divisor 0.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; w_hi, w_lo, busy, done, div_zero and all internal registers = 0. Takes effect immediately, including mid-operation; the aborted operation leaves no partial result.
- States: IDLE, MULT, DIV, DONE.
- IDLE -> MULT on start_mult. IDLE -> DIV on start_div. Both starts high in the same cycle: MULT wins, start_div is ignored.
- Start handling: the start edge (call it k) latches w_opA/w_opB magnitudes and result signs, clears the step counter and clears div_zero.
- Starts seen outside IDLE are ignored; there is no queuing.
- Operand hold: after edge k the operands may change freely; only the latched copies are used.
- MULT:
  - Unsigned shift-add on magnitudes, one bit per edge.
  - 32 steps on edges k+1..k+32.
  - At edge k+32, the 64-bit result is negated if sign(A) XOR sign(B), written to {w_hi,w_lo}, and the state goes to DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per edge.
  - 32 steps on edges k+1..k+32.
  - Quotient truncates toward zero, into w_lo. Remainder takes the sign of the dividend, into w_hi.
  - Written at edge k+32, then state goes to DONE.
- Divide by zero:
  - Detected at edge k, when w_opB==0 is latched.
  - At edge k+1 the unit goes straight to DONE with div_zero=1; w_hi/w_lo are NOT updated.
- Overflow case -2^31 / -1: w_lo=0x80000000, w_hi=0 (natural wrap); no flag.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE on the next edge. Therefore done is high in the cycle after edge k+32, or after edge k+1 for divide-by-zero.
- Result hold: w_hi/w_lo hold their value until the next successful completion or reset. div_zero holds until the next start.
- busy rises in the cycle after edge k and falls in the cycle after DONE. busy is never high while in IDLE.
- Results are registered; outputs never show intermediate partial products or remainders.
- Implementation latency is fixed at 33 cycles from the start edge to the done pulse for MULT and for non-zero DIV. Early termination is not permitted.

Test Plan:
- MULT 7 x -3 (w_opA=0x00000007, w_opB=0xFFFFFFFD), start_mult pulse at edge k -> done high for one cycle after edge k+32; w_hi=0xFFFFFFFF, w_lo=0xFFFFFFEB; busy low the cycle after.
- MULT 0x80000000 x 0x80000000 -> w_hi=0x40000000, w_lo=0x00000000. Then MULT 0xFFFFFFFF x 0xFFFFFFFF -> w_hi=0, w_lo=1.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> w_lo=0xFFFFFFFD, w_hi=0xFFFFFFFF. DIV 100 / -7 -> w_lo=0xFFFFFFF2, w_hi=0x00000002.
- Divide by zero:
  - Preload via a prior MULT so w_hi=0x11111111, w_lo=0x22222222.
  - DIV 5 / 0 -> done one cycle after edge k+1, div_zero=1, w_hi/w_lo unchanged.
  - Next MULT start clears div_zero.
- Handshake:
  - start_mult and start_div together -> multiply result only.
  - start_div pulsed at edge k+10 during MULT -> ignored; no second done.
  - Operands changed after edge k -> result unaffected.
- Async reset:
  - Assert reset_n=0 mid-MULT at step 15, between clock edges -> outputs 0 immediately.
  - After release, the unit stays in IDLE with no done pulse; a fresh MULT 6x7 -> w_lo=42, w_hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with signs applied once when the result is written to HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] w_opA,
  input  logic [WIDTH-1:0] w_opB,
  output logic [WIDTH-1:0] w_hi,
  output logic [WIDTH-1:0] w_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH-1:0]   workHi, workLo;
  logic [CW-1:0]      stepCount;
  logic               negMain, negRem, divByZero;

  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [WIDTH-1:0]   stepHi, stepLo;
  logic [2*WIDTH-1:0] prodMag, prodSigned;
  logic [WIDTH-1:0]   quoSigned, remSigned;

  assign absA = w_opA[WIDTH-1] ? -w_opA : w_opA;
  assign absB = w_opB[WIDTH-1] ? -w_opB : w_opB;

  // workHi:workLo is the running product (MULT) or remainder:dividend/quotient (DIV).
  assign mulSum   = {1'b0, workHi} + (workLo[0] ? {1'b0, magA} : '0);
  assign divShift = {workHi, workLo[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, magB};

  always_comb begin
    stepHi = workHi;
    stepLo = workLo;
    if (state == MULT) begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], workLo[WIDTH-1:1]};
    end else if (state == DIV) begin
      if (!divDiff[WIDTH]) begin
        stepHi = divDiff[WIDTH-1:0];
        stepLo = {workLo[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = divShift[WIDTH-1:0];
        stepLo = {workLo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign prodMag    = {stepHi, stepLo};
  assign prodSigned = negMain ? -prodMag : prodMag;
  assign quoSigned  = negMain ? -stepLo : stepLo;
  assign remSigned  = negRem ? -stepHi : stepHi;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      magA      <= '0;
      magB      <= '0;
      workHi    <= '0;
      workLo    <= '0;
      stepCount <= '0;
      negMain   <= 1'b0;
      negRem    <= 1'b0;
      divByZero <= 1'b0;
      w_hi      <= '0;
      w_lo      <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            magA      <= absA;
            magB      <= absB;
            workHi    <= '0;
            workLo    <= start_mult ? absB : absA;
            stepCount <= '0;
            negMain   <= w_opA[WIDTH-1] ^ w_opB[WIDTH-1];
            negRem    <= w_opA[WIDTH-1];
            divByZero <= !start_mult && (w_opB == '0);
            div_zero  <= 1'b0;
            state     <= start_mult ? MULT : DIV;
          end
        end
        MULT: begin
          workHi    <= stepHi;
          workLo    <= stepLo;
          stepCount <= stepCount + 1'b1;
          if (stepCount == LAST_STEP) begin
            {w_hi, w_lo} <= prodSigned;
            state        <= DONE;
          end
        end
        DIV: begin
          if (divByZero) begin
            // HI/LO keep the previous result; only the flag reports the fault.
            div_zero <= 1'b1;
            state    <= DONE;
          end else begin
            workHi    <= stepHi;
            workLo    <= stepLo;
            stepCount <= stepCount + 1'b1;
            if (stepCount == LAST_STEP) begin
              w_lo  <= quoSigned;
              w_hi  <= remSigned;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a 64-bit arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic [W-1:0] w_opA = '0;
  logic [W-1:0] w_opB = '0;
  logic [W-1:0] w_hi, w_lo;
  logic         busy, done, div_zero;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start_mult(start_mult), .start_div(start_div),
    .w_opA(w_opA), .w_opB(w_opB), .w_hi(w_hi), .w_lo(w_lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int totalCount = 0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;
  logic         expDz = 1'b0;
  int           expLat = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    totalCount++;
    assert (obs === expv) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference: plain signed 64-bit arithmetic; truncating divide, remainder follows dividend.
  function automatic void model(input bit isMult, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (isMult) begin
      r64 = sa * sb;
      expHi = r64[63:32];
      expLo = r64[31:0];
      expDz = 1'b0;
      expLat = 33;
    end else if (b == '0) begin
      expDz = 1'b1;
      expLat = 2;
    end else begin
      r64 = sa / sb;
      expLo = r64[31:0];
      r64 = sa % sb;
      expHi = r64[31:0];
      expDz = 1'b0;
      expLat = 33;
    end
    exp_q.push_back(expHi);
    exp_q.push_back(expLo);
  endfunction

  task automatic runOp(input string tag, input bit isMult, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit both, input int divPulseAt,
                       input bit scramble);
    int lat;
    bit extraDone;
    logic [W-1:0] eh, el;
    model(isMult, a, b);
    @(negedge clk);
    w_opA = a;
    w_opB = b;
    start_mult = isMult | both;
    start_div = !isMult | both;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div = 1'b0;
    if (scramble) begin
      w_opA = $urandom;
      w_opB = $urandom;
    end
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start_div = (i == divPulseAt);
      if (done) begin
        lat = i;
        break;
      end
    end
    start_div = 1'b0;
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(expLat));
    check({tag, "_hi"}, 64'(w_hi), 64'(eh));
    check({tag, "_lo"}, 64'(w_lo), 64'(el));
    check({tag, "_divzero"}, 64'(div_zero), 64'(expDz));
    @(negedge clk);
    check({tag, "_done_fall"}, {62'd0, done, busy}, 64'd0);
    if (divPulseAt != 0) begin
      extraDone = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done) extraDone = 1'b1;
      end
      check({tag, "_no_second_done"}, 64'(extraDone), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bit isMult;
    bit sawDone;
    logic [W-1:0] ra, rb;

    #12;
    check("reset_state", {w_hi, w_lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    runOp("mul_7_m3", 1, 32'h0000_0007, 32'hFFFF_FFFD, 0, 0, 0);
    runOp("mul_min_min", 1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    runOp("mul_m1_m1", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    runOp("div_m7_2", 0, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0);
    runOp("div_100_m7", 0, 32'd100, 32'hFFFF_FFF9, 0, 0, 0);
    runOp("div_ovf", 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    runOp("preload", 1, 32'h5555_5556, 32'h3333_3333, 0, 0, 0);
    check("preload_const", {w_hi, w_lo}, 64'h1111_1111_2222_2222);
    runOp("div_by_zero", 0, 32'd5, 32'd0, 0, 0, 0);
    runOp("mul_clears_dz", 1, 32'h0000_1234, 32'hFFFF_0001, 0, 0, 0);
    runOp("both_starts", 1, 32'hFFFF_FF00, 32'h0000_0300, 1, 0, 0);
    runOp("div_pulse_mid", 1, 32'h0BAD_F00D, 32'h0000_0101, 0, 10, 0);
    runOp("mul_scramble", 1, 32'h7FFF_FFFF, 32'h8000_0001, 0, 0, 1);
    runOp("div_scramble", 0, 32'h8765_4321, 32'h0000_0123, 0, 0, 1);

    for (int n = 0; n < 24; n++) begin
      isMult = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      if (!isMult && $urandom_range(0, 5) == 0) rb = '0;
      runOp("rand", isMult, ra, rb, 0, 0, 0);
    end

    // Asynchronous reset in the middle of a multiply, between clock edges.
    @(negedge clk);
    w_opA = 32'h1234_5678;
    w_opB = 32'h9ABC_DEF0;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_data", {w_hi, w_lo}, 64'd0);
    check("async_reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expHi = '0;
    expLo = '0;
    expDz = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    check("post_reset_idle", 64'(sawDone), 64'd0);
    runOp("mul_6_7", 1, 32'd6, 32'd7, 0, 0, 0);
    check("mul_6_7_const", {w_hi, w_lo}, 64'd42);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
